// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and fault cause codes for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_RESP = 2'b10} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store strobe/shift generation and load byte/half extraction with extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_shifted,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_ext
);
  logic [31:0] ld_lane;
  logic        sgn;
  // funct3[1:0] selects the size; funct3[2] marks zero-extending loads
  always_comb begin
    st_strb    = (st_funct3[1:0] == F3_W[1:0]) ? 4'b1111 :
                 (st_funct3[1:0] == F3_H[1:0]) ? 4'b0011 << st_off : 4'b0001 << st_off;
    st_shifted = st_data << {st_off, 3'b000};
    ld_lane    = ld_raw >> {ld_off, 3'b000};
    sgn        = !ld_funct3[2];
    ld_ext     = (ld_funct3[1:0] == F3_W[1:0]) ? ld_raw :
                 (ld_funct3[1:0] == F3_H[1:0]) ? {{16{sgn & ld_lane[15]}}, ld_lane[15:0]} :
                                                 {{24{sgn & ld_lane[7]}}, ld_lane[7:0]};
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: checks and issues one load/store to data_mem and returns a held load/fault response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic        mem_re,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);
  state_t      state, next;
  logic        fire, illegal, range_err, misalign, fault;
  logic [1:0]  cause;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [3:0]  strb;
  logic [31:0] ld_ext;
  lsu_lane_align u_align (
    .st_funct3 (req_funct3),
    .st_off    (req_addr[1:0]),
    .st_data   (req_wdata),
    .st_strb   (strb),
    .st_shifted(mem_wdata),
    .ld_funct3 (ld_funct3),
    .ld_off    (ld_off),
    .ld_raw    (mem_rdata),
    .ld_ext    (ld_ext)
  );
  // request checks in priority order, memory strobes and next-state selection
  always_comb begin
    req_ready  = (state == S_IDLE) && !rst;
    fire       = req_valid && req_ready;
    illegal    = req_we ? (req_funct3 > F3_W) : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    range_err  = req_addr >= 32'(DMEM_BYTES);
    misalign   = (req_funct3[1:0] == F3_H[1:0] && req_addr[0]) ||
                 (req_funct3[1:0] == F3_W[1:0] && req_addr[1:0] != 2'b00);
    cause      = illegal ? CAUSE_ILLEGAL : range_err ? CAUSE_RANGE : misalign ? CAUSE_MISALIGN : CAUSE_NONE;
    fault      = cause != CAUSE_NONE;
    mem_we     = fire && req_we && !fault;
    mem_re     = fire && !req_we && !fault;
    mem_wstrb  = mem_we ? strb : 4'b0000;
    mem_waddr  = {req_addr[31:2], 2'b00};
    mem_raddr  = {req_addr[31:2], 2'b00};
    resp_valid = state == S_RESP;
    next       = state;
    if (state == S_IDLE && fire && fault) next = S_RESP;
    else if (mem_re) next = S_WAIT;
    else if (state == S_WAIT) next = S_RESP;
    else if (state == S_RESP && resp_ready) next = S_IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? S_IDLE : next;
  // capture request context on fire and the extended load data in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_err   <= 1'b0;
      resp_cause <= CAUSE_NONE;
      ld_funct3  <= F3_B;
      ld_off     <= 2'b00;
    end else if (fire && !mem_we) begin
      resp_data  <= '0;
      resp_rd    <= req_rd;
      resp_err   <= fault;
      resp_cause <= cause;
      ld_funct3  <= req_funct3;
      ld_off     <= req_addr[1:0];
    end else if (state == S_WAIT) begin
      resp_data  <= ld_ext;
    end
  end
endmodule
